// File: rtl/gan_output_serializer.sv
// Collects one GAN sample (nine generator pixels + discriminator score) at fixed
// latencies after start and streams it out as ten indexed words over valid/ready.
module gan_output_serializer #(
    parameter int WIDTH    = 32,
    parameter int PIX_LAT  = 6,
    parameter int DISC_LAT = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    start_ready,
    input  logic signed [WIDTH-1:0] pixel_1x1,
    input  logic signed [WIDTH-1:0] pixel_1x2,
    input  logic signed [WIDTH-1:0] pixel_1x3,
    input  logic signed [WIDTH-1:0] pixel_2x1,
    input  logic signed [WIDTH-1:0] pixel_2x2,
    input  logic signed [WIDTH-1:0] pixel_2x3,
    input  logic signed [WIDTH-1:0] pixel_3x1,
    input  logic signed [WIDTH-1:0] pixel_3x2,
    input  logic signed [WIDTH-1:0] pixel_3x3,
    input  logic signed [WIDTH-1:0] out_discriminator,
    output logic signed [WIDTH-1:0] out_data,
    output logic [3:0]              out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [15:0]             frame_cnt
);
    localparam int CW = $clog2(DISC_LAT + 1);
    // The counter holds the number of edges already seen since start, so a
    // capture fires when it is one below the target latency.
    localparam logic [CW-1:0] PIX_C   = CW'(PIX_LAT - 1);
    localparam logic [CW-1:0] DISC_C1 = CW'(DISC_LAT - 1);
    localparam logic [CW-1:0] DISC_C  = CW'(DISC_LAT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0]              state;
    logic [CW-1:0]           cnt;
    logic signed [WIDTH-1:0] slot [10];
    logic signed [WIDTH-1:0] pix  [9];

    assign pix = '{pixel_1x1, pixel_1x2, pixel_1x3,
                   pixel_2x1, pixel_2x2, pixel_2x3,
                   pixel_3x1, pixel_3x2, pixel_3x3};

    // Outputs decode registered state only, so out_valid never sees out_ready.
    assign start_ready = (state == S_IDLE);
    assign out_valid   = (state == S_SEND);
    assign out_last    = out_valid && (out_idx == 4'd9);
    assign out_data    = slot[out_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_idx   <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < 10; i++) slot[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != DISC_C) cnt <= cnt + 1'b1;
                    if (cnt == PIX_C)
                        for (int i = 0; i < 9; i++) slot[i] <= pix[i];
                    if (cnt == DISC_C1) begin
                        slot[9] <= out_discriminator;
                        out_idx <= '0;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (out_idx == 4'd9) begin
                            out_idx   <= '0;
                            frame_cnt <= frame_cnt + 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gan_output_serializer.sv
// Randomized bench for gan_output_serializer: a per-frame model of the ten
// expected words, latency window and frame count, sampled on the falling edge.
module tb_gan_output_serializer;
    localparam int W        = 32;
    localparam int PIX_LAT  = 3;
    localparam int DISC_LAT = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                start_ready;
    logic signed [W-1:0] pix [9];
    logic signed [W-1:0] disc;
    logic signed [W-1:0] out_data;
    logic [3:0]          out_idx;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [15:0]         frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    gan_output_serializer #(.WIDTH(W), .PIX_LAT(PIX_LAT), .DISC_LAT(DISC_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .pixel_1x1(pix[0]), .pixel_1x2(pix[1]), .pixel_1x3(pix[2]),
        .pixel_2x1(pix[3]), .pixel_2x2(pix[4]), .pixel_2x3(pix[5]),
        .pixel_3x1(pix[6]), .pixel_3x2(pix[7]), .pixel_3x3(pix[8]),
        .out_discriminator(disc), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Inputs outside the capture edges carry junk the DUT must not latch.
    task automatic drive_junk(input bit directed);
        for (int k = 0; k < 9; k++) pix[k] = directed ? 32'hDEAD : $urandom;
        disc = directed ? 32'hDEAD : $urandom;
    endtask

    // Called and returns on a falling edge. rdy_mode: 0 always, 1 toggle, 2 random.
    // abort_idx >= 0 pulls reset while that word is being offered.
    task automatic run_frame(input int rdy_mode, input bit directed, input int abort_idx);
        logic [31:0] expw [10];
        int i;
        int cyc;
        for (int k = 0; k < 10; k++)
            expw[k] = directed ? ((k < 9) ? 32'(k + 1) : 32'd100) : $urandom;
        chk("idle_start_ready", {31'b0, start_ready}, 1);
        start = 1'b1;
        drive_junk(directed);
        for (int e = 1; e <= DISC_LAT; e++) begin
            @(negedge clk);
            chk("wait_valid", {31'b0, out_valid}, 0);
            chk("wait_start_ready", {31'b0, start_ready}, 0);
            start = 1'($urandom_range(0, 1));
            drive_junk(directed);
            if (e == PIX_LAT) for (int k = 0; k < 9; k++) pix[k] = expw[k];
            if (e == DISC_LAT) disc = expw[9];
        end
        i = 0;
        cyc = 0;
        while (i < 10 && cyc < 100) begin
            @(negedge clk);
            drive_junk(directed);
            if (i == abort_idx) begin
                rst = 1'b0;
                start = 1'b0;
                #1;
                chk("rst_valid", {31'b0, out_valid}, 0);
                chk("rst_start_ready", {31'b0, start_ready}, 1);
                chk("rst_frame_cnt", {16'b0, frame_cnt}, 0);
                chk("rst_idx", {28'b0, out_idx}, 0);
                chk("rst_data", out_data, 0);
                exp_frames = 0;
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("post_rst_valid", {31'b0, out_valid}, 0);
                chk("post_rst_start_ready", {31'b0, start_ready}, 1);
                return;
            end
            chk("send_valid", {31'b0, out_valid}, 1);
            chk("send_idx", {28'b0, out_idx}, 32'(i));
            chk("send_data", out_data, expw[i]);
            chk("send_last", {31'b0, out_last}, (i == 9) ? 1 : 0);
            start = 1'($urandom_range(0, 1));
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_ready) i++;
            cyc++;
        end
        if (i < 10) chk("send_timeout", 32'(i), 10);
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        exp_frames = (exp_frames + 1) & 16'hFFFF;
        chk("done_valid", {31'b0, out_valid}, 0);
        chk("done_start_ready", {31'b0, start_ready}, 1);
        chk("done_frame_cnt", {16'b0, frame_cnt}, 32'(exp_frames));
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) pix[k] = '0;
        disc = '0;
        repeat (3) @(negedge clk);
        chk("reset_start_ready", {31'b0, start_ready}, 1);
        chk("reset_valid", {31'b0, out_valid}, 0);
        chk("reset_idx", {28'b0, out_idx}, 0);
        chk("reset_last", {31'b0, out_last}, 0);
        chk("reset_data", out_data, 0);
        chk("reset_frame_cnt", {16'b0, frame_cnt}, 0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        run_frame(0, 1'b1, -1);   // directed 1..9,100 with ready held high
        run_frame(1, 1'b1, -1);   // back-to-back start, toggling backpressure
        for (int f = 0; f < 6; f++) run_frame(2, 1'b0, -1);
        run_frame(0, 1'b0, 4);    // reset while word 4 is offered
        run_frame(2, 1'b0, -1);

        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        exp_frames = 16'hFFFF;
        chk("preload_frame_cnt", {16'b0, frame_cnt}, 32'hFFFF);
        run_frame(2, 1'b0, -1);   // wraps to 0

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
